// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: shared FSM encoding and framing constants for the boot loader.
package imem_boot_loader_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
    } state_e;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_boot_loader_word_packer.sv
// imem_boot_loader_word_packer: packs bytes little-endian into a word and keeps a running XOR.
module imem_boot_loader_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        clr_i,
    input  logic        xfer_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o,
    output logic [7:0]  xor_o
);
    logic [1:0]  idx_q;
    logic [31:0] word_q;
    logic [7:0]  xor_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            idx_q  <= '0;
            word_q <= '0;
            xor_q  <= '0;
        end else if (xfer_i) begin
            word_q[8*idx_q +: 8] <= byte_i;
            idx_q                <= idx_q + 2'd1;
            xor_q                <= xor_q ^ byte_i;
        end
    end

    assign word_o       = word_q;
    assign xor_o        = xor_q;
    assign word_ready_o = xfer_i && (idx_q == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a length-prefixed, XOR-checked byte stream, writes it into
// instruction memory and holds the core in reset until the load is verified.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byteIn,
    input  logic                  byteValid,
    output logic                  byteReady,
    output logic                  imemWrEn,
    output logic [ADDR_WIDTH-1:0] imemAddr,
    output logic [31:0]           imemWrData,
    output logic                  coreReset,
    output logic                  loadDone,
    output logic                  loadError
);
    localparam int CAPACITY = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [ADDR_WIDTH:0]   widx_q, widx_d;
    logic [31:0]           wdata_q;
    logic [31:0]           pk_word;
    logic [7:0]            pk_xor;
    logic                  pk_ready;
    logic                  xfer;
    logic [15:0]           n_full;

    assign byteReady = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                       (state_q == S_DATA)   || (state_q == S_CHECK);
    assign xfer      = byteValid && byteReady;
    assign n_full    = {byteIn, len_q[7:0]};

    imem_boot_loader_word_packer u_packer (
        .clk          (clk),
        .clr_i        (reset || (state_q == S_IDLE)),
        .xfer_i       (xfer && (state_q == S_DATA)),
        .byte_i       (byteIn),
        .word_o       (pk_word),
        .word_ready_o (pk_ready),
        .xor_o        (pk_xor)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        widx_d  = widx_q;
        case (state_q)
            S_IDLE:   state_d = start ? S_LEN_LO : S_IDLE;
            S_LEN_LO: if (xfer) begin
                len_d[7:0] = byteIn;
                state_d    = S_LEN_HI;
            end
            S_LEN_HI: if (xfer) begin
                len_d   = n_full;
                state_d = (32'(n_full) > CAPACITY) ? S_ERROR :
                          (n_full == 16'd0)        ? S_CHECK : S_DATA;
            end
            S_DATA:   state_d = pk_ready ? S_WRITE : S_DATA;
            S_WRITE: begin
                widx_d  = widx_q + 1'b1;
                state_d = (16'(widx_d) == len_q) ? S_CHECK : S_DATA;
            end
            S_CHECK:  if (xfer) state_d = (byteIn == pk_xor) ? S_DONE : S_ERROR;
            default:  state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            widx_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= (state_q == S_IDLE) ? '0 : len_d;
            widx_q  <= (state_q == S_IDLE) ? '0 : widx_d;
            if (state_q == S_WRITE) wdata_q <= pk_word;
        end
    end

    // The packed word is complete once WRITE is entered; the register keeps it afterwards.
    assign imemWrEn   = (state_q == S_WRITE);
    assign imemWrData = imemWrEn ? pk_word : wdata_q;
    assign imemAddr   = BASE + widx_q[ADDR_WIDTH-1:0];
    assign coreReset  = (state_q != S_DONE);
    assign loadDone   = (state_q == S_DONE);
    assign loadError  = (state_q == S_ERROR);
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed frames with hand-computed writes, checksums and status flags.
module tb_imem_boot_loader;
    logic        clk = 1'b0;
    logic        reset, start, byteValid;
    logic [7:0]  byteIn;
    logic        byteReady, imemWrEn, coreReset, loadDone, loadError;
    logic [7:0]  imemAddr;
    logic [31:0] imemWrData;

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt;
    logic [31:0] wdata [4];
    logic [7:0]  waddr [4];
    logic        rdy_bad;
    logic [7:0]  prog [8];

    imem_boot_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start), .byteIn(byteIn), .byteValid(byteValid),
        .byteReady(byteReady), .imemWrEn(imemWrEn), .imemAddr(imemAddr),
        .imemWrData(imemWrData), .coreReset(coreReset), .loadDone(loadDone),
        .loadError(loadError)
    );

    always #5 clk = ~clk;

    // Write monitor: logs each strobe and flags byteReady seen high during WRITE.
    always @(posedge clk) begin
        if (reset) begin
            wr_cnt  <= 0;
            rdy_bad <= 1'b0;
        end else if (imemWrEn) begin
            if (wr_cnt < 4) begin
                wdata[wr_cnt] <= imemWrData;
                waddr[wr_cnt] <= imemAddr;
            end
            wr_cnt <= wr_cnt + 1;
            if (byteReady) rdy_bad <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; byteValid = 1'b0; byteIn = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        int n = 0;
        @(negedge clk);
        if (gap && $urandom_range(0, 1) == 1) begin
            byteValid = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        byteValid = 1'b1;
        byteIn    = b;
        while (!byteReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!byteReady) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed byteReady=0 expected byteReady=1 byte %h", b);
        end
        @(posedge clk);
        #1 byteValid = 1'b0;
    endtask

    task automatic frame(input logic [15:0] n, input int nbytes, input bit send_chk,
                         input logic [7:0] c, input bit gap);
        pulse_start();
        send(n[7:0], gap);
        send(n[15:8], gap);
        for (int i = 0; i < nbytes; i++) send(prog[i], gap);
        if (send_chk) send(c, gap);
    endtask

    initial begin
        prog = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

        do_reset();
        @(negedge clk);
        chk("rst_byteReady",  32'(byteReady),  32'd0);
        chk("rst_imemWrEn",   32'(imemWrEn),   32'd0);
        chk("rst_imemAddr",   32'(imemAddr),   32'd0);
        chk("rst_imemWrData", imemWrData,      32'd0);
        chk("rst_coreReset",  32'(coreReset),  32'd1);
        chk("rst_loadDone",   32'(loadDone),   32'd0);
        chk("rst_loadError",  32'(loadError),  32'd0);
        chk("idle_no_ready",  32'(byteReady),  32'd0);

        // Good frame: two words, checksum C0
        frame(16'd2, 8, 1'b1, 8'hC0, 1'b0);
        chk("good_done",      32'(loadDone),  32'd1);
        chk("good_coreReset", 32'(coreReset), 32'd0);
        chk("good_noerr",     32'(loadError), 32'd0);
        chk("good_wrcnt",     32'(wr_cnt),    32'd2);
        chk("good_addr0",     32'(waddr[0]),  32'd0);
        chk("good_data0",     wdata[0],       32'h00500013);
        chk("good_addr1",     32'(waddr[1]),  32'd1);
        chk("good_data1",     wdata[1],       32'h00100093);
        chk("good_rdy_write", 32'(rdy_bad),   32'd0);
        chk("done_holds_data", imemWrData,    32'h00100093);
        pulse_start();
        chk("done_terminal",  32'(loadDone),  32'd1);
        chk("done_no_ready",  32'(byteReady), 32'd0);

        // Bad checksum: writes still happen, then ERROR
        do_reset();
        frame(16'd2, 8, 1'b1, 8'h00, 1'b0);
        chk("badchk_err",       32'(loadError), 32'd1);
        chk("badchk_done",      32'(loadDone),  32'd0);
        chk("badchk_coreReset", 32'(coreReset), 32'd1);
        chk("badchk_wrcnt",     32'(wr_cnt),    32'd2);
        chk("badchk_data1",     wdata[1],       32'h00100093);

        // Oversized length: 0x0101 > 256 words
        do_reset();
        frame(16'h0101, 0, 1'b0, 8'h00, 1'b0);
        chk("len_err",       32'(loadError), 32'd1);
        chk("len_coreReset", 32'(coreReset), 32'd1);
        chk("len_no_ready",  32'(byteReady), 32'd0);
        repeat (3) @(negedge clk);
        chk("len_no_write",  32'(wr_cnt),    32'd0);

        // Zero-length frames
        do_reset();
        frame(16'd0, 0, 1'b1, 8'h00, 1'b0);
        chk("n0_done",   32'(loadDone),  32'd1);
        chk("n0_core",   32'(coreReset), 32'd0);
        chk("n0_nowr",   32'(wr_cnt),    32'd0);
        do_reset();
        frame(16'd0, 0, 1'b1, 8'hFF, 1'b0);
        chk("n0ff_err",  32'(loadError), 32'd1);
        chk("n0ff_done", 32'(loadDone),  32'd0);

        // Random byteValid gaps must not change the outcome
        do_reset();
        frame(16'd2, 8, 1'b1, 8'hC0, 1'b1);
        chk("gap_done",   32'(loadDone), 32'd1);
        chk("gap_wrcnt",  32'(wr_cnt),   32'd2);
        chk("gap_data0",  wdata[0],      32'h00500013);
        chk("gap_addr1",  32'(waddr[1]), 32'd1);
        chk("gap_data1",  wdata[1],      32'h00100093);
        chk("gap_rdy_wr", 32'(rdy_bad),  32'd0);

        // start during DATA is ignored; reset after 5th byte, then full reload
        do_reset();
        frame(16'd2, 3, 1'b0, 8'h00, 1'b0);
        pulse_start();
        send(prog[3], 1'b0);
        send(prog[4], 1'b0);
        chk("mid_wrcnt",  32'(wr_cnt),    32'd1);
        chk("mid_data0",  wdata[0],       32'h00500013);
        chk("mid_ready",  32'(byteReady), 32'd1);
        do_reset();
        chk("mid_rst_core", 32'(coreReset), 32'd1);
        chk("mid_rst_addr", 32'(imemAddr),  32'd0);
        frame(16'd2, 8, 1'b1, 8'hC0, 1'b0);
        chk("reload_done",  32'(loadDone), 32'd1);
        chk("reload_wrcnt", 32'(wr_cnt),   32'd2);
        chk("reload_addr0", 32'(waddr[0]), 32'd0);
        chk("reload_data0", wdata[0],      32'h00500013);
        chk("reload_data1", wdata[1],      32'h00100093);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
